// File: rtl/gray_stream_checker.sv
// gray_stream_checker
// Decodes a Gray-coded valid/ready stream back to binary, classifies each
// accepted word against the previous one (up, down, hold, bad), tracks lock
// status and a saturating error count, and forwards the decoded word through
// a one-deep output register.
module gray_stream_checker #(
    parameter int WIDTH         = 8,
    parameter int LOCK_LEN      = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     valid_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     dir_o,
    output logic                     err_o,
    output logic                     locked_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        ST_UNSYNC,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_BAD
    } step_t;

    localparam logic [7:0]       LOCK_LEN_C = 8'(LOCK_LEN);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    state_t                     state;
    state_t                     state_n;
    logic   [7:0]               run;
    logic   [7:0]               run_n;
    logic                       dirl;
    logic                       dirl_n;
    logic   [WIDTH-1:0]         prev;
    logic   [WIDTH-1:0]         prev_inc;
    logic   [WIDTH-1:0]         prev_dec;
    logic   [WIDTH-1:0]         bin;
    step_t                      step;
    logic                       accept;
    logic                       beat_err;
    logic                       beat_dir;
    logic                       err_sat;

    // A clear cycle swallows any input, so ready drops with clr_i.
    assign ready_o  = !clr_i && (!valid_o || ready_i);
    assign accept   = valid_i && ready_o;
    assign prev_inc = prev + ONE;
    assign prev_dec = prev - ONE;
    assign err_sat  = &err_cnt_o;

    // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
    always_comb begin
        bin            = '0;
        bin[WIDTH-1]   = data_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ data_i[i];
        end
    end

    // Classify the incoming word relative to the last accepted word (mod 2^WIDTH).
    always_comb begin
        if (bin == prev) begin
            step = STEP_HOLD;
        end else if (bin == prev_inc) begin
            step = STEP_UP;
        end else if (bin == prev_dec) begin
            step = STEP_DOWN;
        end else begin
            step = STEP_BAD;
        end
    end

    // Lock FSM next-state, run counter and per-beat err/dir flags.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n  = state;
        run_n    = run;
        dirl_n   = dirl;
        beat_err = 1'b0;
        beat_dir = 1'b0;
        case (state)
            ST_UNSYNC: begin
                state_n = ST_ACQUIRE;
                run_n   = 8'd0;
            end
            ST_ACQUIRE: begin
                case (step)
                    STEP_UP, STEP_DOWN: begin
                        beat_dir = (step == STEP_UP);
                        dirl_n   = beat_dir;
                        if (run == 8'd0 || beat_dir == dirl) begin
                            run_n = run + 8'd1;
                        end else begin
                            run_n = 8'd1;
                        end
                        if (run_n == LOCK_LEN_C) begin
                            state_n = ST_LOCKED;
                        end
                    end
                    STEP_BAD: begin
                        beat_err = 1'b1;
                        run_n    = 8'd0;
                    end
                    default: ;
                endcase
            end
            ST_LOCKED: begin
                case (step)
                    STEP_UP, STEP_DOWN: begin
                        beat_dir = (step == STEP_UP);
                        if (beat_dir != dirl) begin
                            beat_err = 1'b1;
                            state_n  = ST_ACQUIRE;
                            run_n    = 8'd0;
                        end
                    end
                    STEP_BAD: begin
                        beat_err = 1'b1;
                        state_n  = ST_ACQUIRE;
                        run_n    = 8'd0;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_n = ST_UNSYNC;
                run_n   = 8'd0;
            end
        endcase
    end

    // Checker state: FSM, run, latched direction, previous word, lock flag, error count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            state     <= ST_UNSYNC;
            run       <= 8'd0;
            dirl      <= 1'b0;
            prev      <= '0;
            locked_o  <= 1'b0;
            err_cnt_o <= '0;
        end else if (clr_i) begin
            state     <= ST_UNSYNC;
            run       <= 8'd0;
            dirl      <= 1'b0;
            prev      <= '0;
            locked_o  <= 1'b0;
            err_cnt_o <= '0;
        end else if (accept) begin
            state    <= state_n;
            run      <= run_n;
            dirl     <= dirl_n;
            prev     <= bin;
            locked_o <= (state_n == ST_LOCKED);
            if (beat_err && !err_sat) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

    // One-deep output register: load on accept, drain when downstream takes the beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            dir_o   <= 1'b0;
            err_o   <= 1'b0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            dir_o   <= 1'b0;
            err_o   <= 1'b0;
        end else if (accept) begin
            valid_o <= 1'b1;
            data_o  <= bin;
            dir_o   <= beat_dir;
            err_o   <= beat_err;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
